// File: rtl/ob_tbl_arb.sv
// ob_tbl_arb
// ----------------------------------------------------------------------------
// Single-issue arbiter and sequencer in front of one order-book side table.
// Requests from the matching engine (pop, head update, head push) and the
// command path (cancel, insert) are arbitrated so that at most one table
// modification is issued per cycle. After any head modification the head
// operations are held off for one cycle (SETTLE) so the table's registered
// head can reflect the change before the matcher acts on it again.
//
// Optional feature macro: OB_TBL_ARB_AGING_EN
//   defined     -> an 8-bit age counter promotes a starved insert above pop
//                  once it has waited AGE_MAX cycles.
//   not defined -> strict fixed priority pop > upt > push > cxl > ins;
//                  AGE_MAX has no effect.
//
// Handshake: every request channel is valid/ready. A transfer happens in a
// cycle where vld & rdy are both 1. rdy is computed from vld (and table
// state), so a requester must never make its vld depend on its rdy.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   pop_vld/pop_rdy                pop head request
//   upt_vld/upt_tbl/upt_rdy        overwrite head entry (partial fill)
//   push_vld/push_tbl/push_rdy     push residual to head
//   cxl_vld/cxl_uid/cxl_rdy        cancel by UID
//   ins_vld/ins_tbl/ins_rdy        append to tail
//   cxl_rsp_vld/_hit/_tbl          registered cancel result (1 cycle pulse)
//   tbl_head_pop/_push/_upt,
//   tbl_insert, tbl_cancel         table strobes, same cycle as grant
//   tbl_head_push_tbl, tbl_head_upt_tbl, tbl_insert_tbl, tbl_cancel_uid
//                                  table payloads, 0 when not selected
//   tbl_cancel_hit_w/_hit_tbl_w    combinational cancel result from table
//   tbl_full_w                     table next-state full
//   tbl_head_vld_r                 table head slot valid
//   dbg_state                      FSM state (0 = RUN, 1 = SETTLE)
// ----------------------------------------------------------------------------
module ob_tbl_arb #(
    parameter int AGE_MAX = 8,
    parameter int UID_W   = 16,
    parameter int TBL_W   = 48
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             pop_vld,
    output logic             pop_rdy,
    input  logic             upt_vld,
    input  logic [TBL_W-1:0] upt_tbl,
    output logic             upt_rdy,
    input  logic             push_vld,
    input  logic [TBL_W-1:0] push_tbl,
    output logic             push_rdy,
    input  logic             cxl_vld,
    input  logic [UID_W-1:0] cxl_uid,
    output logic             cxl_rdy,
    input  logic             ins_vld,
    input  logic [TBL_W-1:0] ins_tbl,
    output logic             ins_rdy,

    output logic             cxl_rsp_vld,
    output logic             cxl_rsp_hit,
    output logic [TBL_W-1:0] cxl_rsp_tbl,

    output logic             tbl_head_pop,
    output logic             tbl_head_push,
    output logic             tbl_head_upt,
    output logic             tbl_insert,
    output logic             tbl_cancel,
    output logic [TBL_W-1:0] tbl_head_push_tbl,
    output logic [TBL_W-1:0] tbl_head_upt_tbl,
    output logic [TBL_W-1:0] tbl_insert_tbl,
    output logic [UID_W-1:0] tbl_cancel_uid,

    input  logic             tbl_cancel_hit_w,
    input  logic [TBL_W-1:0] tbl_cancel_hit_tbl_w,
    input  logic             tbl_full_w,
    input  logic             tbl_head_vld_r,

    output logic             dbg_state
);

    generate
        if (AGE_MAX < 1 || AGE_MAX > 255) begin : g_bad_age
            $error("ob_tbl_arb: AGE_MAX must be in 1..255");
        end
    endgenerate

    typedef enum logic {RUN = 1'b0, SETTLE = 1'b1} state_t;

    state_t state_q;
    state_t state_d;
    logic   settle;

    logic   full_q;

    logic   pop_e, upt_e, push_e, cxl_e, ins_e;
    logic   ins_top;
    logic   head_gnt;

    logic             rsp_vld_q;
    logic             rsp_hit_q;
    logic [TBL_W-1:0] rsp_tbl_q;

    // ------------------------------------------------------------------
    // Full flag: the table reports next-state full, we use it a cycle late
    // so a pop or cancel frees the slot for the following cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) full_q <= 1'b0;
        else     full_q <= tbl_full_w;
    end

    // ------------------------------------------------------------------
    // Eligibility. Everything is masked during reset so no strobe fires
    // in a reset cycle.
    // ------------------------------------------------------------------
    always_comb begin
        pop_e  = ~rst & pop_vld  & tbl_head_vld_r & ~settle;
        upt_e  = ~rst & upt_vld  & tbl_head_vld_r & ~settle;
        push_e = ~rst & push_vld & ~full_q & ~settle;
        cxl_e  = ~rst & cxl_vld;
        ins_e  = ~rst & ins_vld  & ~full_q;
    end

`ifdef OB_TBL_ARB_AGING_EN
    localparam logic [7:0] AGE_LIM = 8'(AGE_MAX);

    logic [7:0] age_q;

    // A starved insert jumps above every other requester for one cycle.
    assign ins_top = ins_e & (age_q == AGE_LIM);

    always_ff @(posedge clk) begin
        if (rst) begin
            age_q <= 8'd0;
        end else if (!ins_vld || ins_rdy) begin
            age_q <= 8'd0;
        end else if (ins_e && age_q != AGE_LIM) begin
            age_q <= age_q + 8'd1;
        end
    end
`else
    assign ins_top = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Fixed priority pop > upt > push > cxl > ins, with optional insert
    // promotion on top. Grants are one-hot.
    // ------------------------------------------------------------------
    always_comb begin
        pop_rdy  = pop_e  & ~ins_top;
        upt_rdy  = upt_e  & ~pop_e & ~ins_top;
        push_rdy = push_e & ~pop_e & ~upt_e & ~ins_top;
        cxl_rdy  = cxl_e  & ~pop_e & ~upt_e & ~push_e & ~ins_top;
        ins_rdy  = ins_e  & (ins_top | ~(pop_e | upt_e | push_e | cxl_e));
    end

    // rdy already implies vld, so the grant is the rdy itself.
    always_comb begin
        tbl_head_pop      = pop_rdy;
        tbl_head_upt      = upt_rdy;
        tbl_head_push     = push_rdy;
        tbl_cancel        = cxl_rdy;
        tbl_insert        = ins_rdy;
        tbl_head_upt_tbl  = upt_rdy  ? upt_tbl  : '0;
        tbl_head_push_tbl = push_rdy ? push_tbl : '0;
        tbl_insert_tbl    = ins_rdy  ? ins_tbl  : '0;
        tbl_cancel_uid    = cxl_rdy  ? cxl_uid  : '0;
    end

    assign head_gnt = pop_rdy | upt_rdy | push_rdy;

    // ------------------------------------------------------------------
    // Head settle FSM: state register / next state / outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) state_q <= RUN;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (head_gnt) state_d = SETTLE;
            SETTLE:  state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        settle    = (state_q == SETTLE);
        dbg_state = (state_q == SETTLE);
    end

    // ------------------------------------------------------------------
    // Cancel response, captured one cycle after the grant. A miss returns
    // an all-zero entry regardless of what the table drives.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_vld_q <= 1'b0;
            rsp_hit_q <= 1'b0;
            rsp_tbl_q <= '0;
        end else begin
            rsp_vld_q <= cxl_rdy;
            rsp_hit_q <= cxl_rdy & tbl_cancel_hit_w;
            rsp_tbl_q <= (cxl_rdy & tbl_cancel_hit_w) ? tbl_cancel_hit_tbl_w : '0;
        end
    end

    // Reset also hides a response already captured, so a reset issued the
    // cycle after a cancel grant drops that response.
    always_comb begin
        cxl_rsp_vld = rsp_vld_q & ~rst;
        cxl_rsp_hit = rsp_hit_q & ~rst;
        cxl_rsp_tbl = rst ? '0 : rsp_tbl_q;
    end

endmodule
